multimode_ff_bank: RTL
======================

// Module: multimode_ff_bank
// PURPOSE
//   WIDTH-bit register bank built from configurable flip-flops. The mode is
//   selectable at run time: D, T, SR or JK.
//   Successor to the single-bit D/T flip-flop. Adds per-bit vector operation,
//   enable and synchronous clear, latched mode switching, a sticky SR-illegal
//   flag and a saturating change counter.
//   Used as a general state register and as a golden-model target in the
//   flip-flop regression benches.
// PARAMETERS
//   WIDTH     8       number of flip-flop bits
//   RST_VAL   8'h00   value of q after async reset or sclr (WIDTH bits)
//   DEF_MODE  2'b00   mode_q after reset (00=D, 01=T, 10=SR, 11=JK)
//   CNT_W     8       width of the change counter
// PORTS
//   clk_tb   in   1      clock, rising-edge active
//   rstn_tb  in   1      reset, asynchronous, active-low
//   a        in   WIDTH  D / T / S / J input, per bit
//   b        in   WIDTH  R / K input, per bit (ignored in D and T modes)
//   en       in   1      update enable for q
//   sclr     in   1      synchronous clear of q to RST_VAL
//   mode_in  in   2      new mode value
//   mode_ld  in   1      load mode_in into mode_q at the next edge
//   stat_clr in   1      clear err_sr and chg_cnt
//   q        out  WIDTH  register state
//   qbar     out  WIDTH  always equal to ~q, including during reset
//   mode_q   out  2      active mode
//   err_sr   out  1      sticky: an SR-mode bit saw S=R=1 while en=1
//   chg_cnt  out  CNT_W  number of edges where q changed; saturates
// BEHAVIOUR
//   Reset (rstn_tb=0, async, immediate): q=RST_VAL, qbar=~RST_VAL,
//     mode_q=DEF_MODE, err_sr=0, chg_cnt=0.
//   Reset mid-operation overrides all other inputs. No partial update is kept.
//   Latency: all outputs are registered. Effects appear 1 edge after the
//     inputs are sampled.
//   q priority at each edge:
//     1. sclr=1         -> q=RST_VAL, regardless of en
//     2. en=1           -> per-bit next state using the current mode_q
//     3. otherwise      -> hold
//   Per-bit next state (a=S/J, b=R/K):
//     D  (00): q=a.  b is ignored.
//     T  (01): q=q^a.  b is ignored.
//     SR (10): a,b = 00 hold | 10 set | 01 clear | 11 hold, and raise err_sr
//     JK (11): a,b = 00 hold | 10 set | 01 clear | 11 toggle
//   Mode switching:
//     - mode_ld=1 sets mode_q to mode_in at the edge.
//     - The edge on which mode_ld is sampled still updates q using the old
//       mode_q. The new mode applies from the following edge.
//     - mode_ld is accepted during sclr and while en=0.
//   err_sr:
//     - Set at the edge where en=1, sclr=0, mode_q=SR and any bit has a&b=1.
//     - Cleared by stat_clr. When set and clear occur on the same edge, set
//       wins.
//   chg_cnt:
//     - Increments by 1 at each edge where next q != current q. Any cause
//       counts, including sclr.
//     - Saturates at all-ones and never wraps.
//     - stat_clr forces it to 0 and wins over an increment on the same edge.
// TESTING
//   1. Reset, then D mode with en=1 and a=8'hA5 -> after 1 edge: q=A5,
//      qbar=5A, chg_cnt=1.
//   2. mode_in=01 and mode_ld=1 on the same edge as a=8'hFF, en=1 -> that
//      edge applies D (q=FF). Next edge with a=8'h0F gives T: q=F0.
//   3. SR mode, q=00, a=8'h03, b=8'h01, en=1 -> q=02 and err_sr=1.
//      Then stat_clr=1 with a=b=00 -> err_sr=0 and chg_cnt=0.
//   4. JK mode, q=8'h0F, a=b=8'hFF -> q=F0. Repeat with en=0 -> q holds F0
//      and chg_cnt does not increment.
//   5. sclr=1 together with en=1 and a=8'h77 in D mode -> q=RST_VAL (00).
//      Then assert rstn_tb=0 between edges -> q=00 and mode_q=00 immediately.
//   6. T mode with a=8'h01 toggling for 300 edges, CNT_W=8 -> chg_cnt stops
//      at 8'hFF. Then compare all outputs against a reference model every
//      cycle under 1000 random-stimulus cycles.

Source files
------------

// File: rtl/multimode_ff_bank.sv
// multimode_ff_bank
//   WIDTH-bit register bank whose bits behave as D, T, SR or JK flip-flops.
//   The mode is chosen at run time and latched: a mode load on an edge takes
//   effect from the following edge. The bank also provides an update enable,
//   a synchronous clear, a sticky SR-illegal flag and a saturating counter of
//   edges on which q changed.
module multimode_ff_bank #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_VAL  = 8'h00,
    parameter logic [1:0]       DEF_MODE = 2'b00,
    parameter int               CNT_W    = 8
) (
    input  logic             clk_tb,
    input  logic             rstn_tb,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    input  logic             sclr,
    input  logic [1:0]       mode_in,
    input  logic             mode_ld,
    input  logic             stat_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [1:0]       mode_q,
    output logic             err_sr,
    output logic [CNT_W-1:0] chg_cnt
);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_SR = 2'b10,
        MODE_JK = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    mode_e            mode_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] ff_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             q_changes;
    logic             sr_illegal;
    logic             err_r;
    logic [CNT_W-1:0] cnt_r;

    // Per-bit flip-flop characteristic equations for the active mode.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        ff_nxt = q_r;
        case (mode_r)
            // D: follow a, b unused.
            MODE_D:  ff_nxt = a;
            // T: toggle where a is set, b unused.
            MODE_T:  ff_nxt = q_r ^ a;
            // SR: set on S only, clear on R only, hold on 00 and on 11.
            MODE_SR: ff_nxt = (q_r | (a & ~b)) & ~(b & ~a);
            // JK: Q+ = J~Q + ~KQ gives hold/set/clear/toggle.
            MODE_JK: ff_nxt = (a & ~q_r) | (~b & q_r);
            default: ff_nxt = q_r;
        endcase
    end

    // Register priority: synchronous clear, then enabled update, else hold.
    always_comb begin
        q_nxt = q_r;
        if (sclr) begin
            q_nxt = RST_VAL;
        end else if (en) begin
            q_nxt = ff_nxt;
        end
    end

    // Event detection feeding the status registers.
    always_comb begin
        q_changes  = (q_nxt != q_r);
        sr_illegal = en && !sclr && (mode_r == MODE_SR) && |(a & b);
    end

    // Bit-bank state register.
    always_ff @(posedge clk_tb or negedge rstn_tb) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rstn_tb) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= q_nxt;
        end
    end

    // Latched mode: the edge that loads it still uses the old mode above.
    always_ff @(posedge clk_tb or negedge rstn_tb) begin
        if (!rstn_tb) begin
            mode_r <= mode_e'(DEF_MODE);
        end else if (mode_ld) begin
            mode_r <= mode_e'(mode_in);
        end
    end

    // Sticky SR-illegal flag; a new set beats a simultaneous clear.
    always_ff @(posedge clk_tb or negedge rstn_tb) begin
        if (!rstn_tb) begin
            err_r <= 1'b0;
        end else if (sr_illegal) begin
            err_r <= 1'b1;
        end else if (stat_clr) begin
            err_r <= 1'b0;
        end
    end

    // Saturating change counter; a clear beats a simultaneous increment.
    always_ff @(posedge clk_tb or negedge rstn_tb) begin
        if (!rstn_tb) begin
            cnt_r <= '0;
        end else if (stat_clr) begin
            cnt_r <= '0;
        end else if (q_changes && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    // Outputs; qbar is derived from q so it tracks q even during reset.
    always_comb begin
        q       = q_r;
        qbar    = ~q_r;
        mode_q  = mode_r;
        err_sr  = err_r;
        chg_cnt = cnt_r;
    end

endmodule
